// File: rtl/imm_decode_ctrl.sv
// ---------------------------------------------------------------------------
// imm_decode_ctrl
//
// Decode-stage controller between the IF/ID handshake and the EX stage.
// Captures instructions, drives imm17/SIG_ExtOp to the external immediate
// extender, and registers the extender result (extImm) as the ID/EX
// immediate. Optionally sequences two-instruction long-immediate pairs:
// a prefix instruction carries 15 upper bits that are concatenated with the
// next immediate-using instruction's 17-bit field.
//
// Configuration macro:
//   IMM_PREFIX_EN  defined   -> prefix FSM (IDLE/PFX) and payload register
//                  undefined -> no prefix support; PFX_OPCODE decodes as
//                               illegal and pfx_err is tied low
//
// Ports:
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous active-high reset
//   if_valid     in   fetch presents an instruction
//   if_instr     in   [31:0] instruction (opcode [31:26], imm17 [16:0])
//   if_ready     out  controller accepts if_instr this cycle
//   ex_ready     in   EX consumes id_* this cycle
//   flush        in   kills held output and any pending prefix
//   imm17        out  [16:0] immediate field to extender (combinational)
//   SIG_ExtOp    out  1 = sign-extend, 0 = zero-extend (combinational)
//   extImm       in   [31:0] extender result
//   id_valid     out  ID/EX holds a valid instruction
//   id_instr     out  [31:0] registered instruction
//   id_imm       out  [31:0] registered final immediate
//   id_uses_imm  out  instruction consumes id_imm
//   id_illegal   out  unknown opcode flag
//   pfx_err      out  one-cycle pulse when a pending prefix is discarded
// ---------------------------------------------------------------------------
module imm_decode_ctrl #(
    parameter logic [5:0]  PFX_OPCODE = 6'h3F,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    input  logic        ex_ready,
    input  logic        flush,
    output logic [16:0] imm17,
    output logic        SIG_ExtOp,
    input  logic [31:0] extImm,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_imm,
    output logic        id_uses_imm,
    output logic        id_illegal,
    output logic        pfx_err
);

    logic [5:0] opcode;
    logic       dec_uses_imm;
    logic       dec_ext_op;
    logic       dec_illegal;
    logic       dec_pfx;
    logic       accept;
    logic       accept_issue;

    assign opcode    = if_instr[31:26];
    assign imm17     = if_instr[16:0];
    assign SIG_ExtOp = dec_ext_op;

    // Flush blocks acceptance in the same cycle it kills the pipeline slot.
    assign if_ready = ~flush & (~id_valid | ex_ready);
    assign accept   = if_valid & if_ready;

    always_comb begin
        dec_uses_imm = 1'b0;
        dec_ext_op   = 1'b0;
        dec_illegal  = 1'b0;
        dec_pfx      = 1'b0;
        case (opcode)
            6'h00:                      ;
            6'h01, 6'h04, 6'h05, 6'h06: begin
                dec_uses_imm = 1'b1;
                dec_ext_op   = 1'b1;
            end
            6'h02, 6'h03:               dec_uses_imm = 1'b1;
            default:                    dec_illegal  = 1'b1;
        endcase
`ifdef IMM_PREFIX_EN
        // Prefix opcode takes priority over the base table.
        if (opcode == PFX_OPCODE) begin
            dec_pfx      = 1'b1;
            dec_uses_imm = 1'b0;
            dec_ext_op   = 1'b0;
            dec_illegal  = 1'b0;
        end
`else
        // Without prefix support the prefix opcode is just an unknown opcode.
        if (opcode == PFX_OPCODE) begin
            dec_uses_imm = 1'b0;
            dec_ext_op   = 1'b0;
            dec_illegal  = 1'b1;
        end
`endif
    end

    assign accept_issue = accept & ~dec_pfx;

`ifdef IMM_PREFIX_EN
    typedef enum logic {
        IDLE = 1'b0,
        PFX  = 1'b1
    } state_t;

    state_t      state;
    logic [14:0] pfx;
    logic        accept_pfx;

    assign accept_pfx = accept & dec_pfx;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_imm      <= '0;
            id_uses_imm <= 1'b0;
            id_illegal  <= 1'b0;
            pfx_err     <= 1'b0;
            state       <= IDLE;
            pfx         <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            pfx_err  <= 1'b0;
            state    <= IDLE;
            pfx      <= '0;
        end else begin
            pfx_err <= 1'b0;
            if (accept_issue) begin
                id_valid    <= 1'b1;
                id_instr    <= if_instr;
                id_uses_imm <= dec_uses_imm;
                id_illegal  <= dec_illegal;
                id_imm      <= dec_uses_imm ? extImm : '0;
                if (state == PFX) begin
                    // Pending prefix either supplies the upper bits (extender
                    // bypassed) or is dropped because nothing consumes it.
                    state <= IDLE;
                    if (dec_uses_imm) begin
                        id_imm <= {pfx, if_instr[16:0]};
                    end else begin
                        pfx_err <= 1'b1;
                    end
                end
            end else if (ex_ready) begin
                id_valid <= 1'b0;
            end

            // A prefix produces no ID/EX output; a second prefix overwrites
            // the first one.
            if (accept_pfx) begin
                pfx   <= if_instr[14:0];
                state <= PFX;
                if (state == PFX) begin
                    pfx_err <= 1'b1;
                end
            end
        end
    end
`else
    assign pfx_err = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_imm      <= '0;
            id_uses_imm <= 1'b0;
            id_illegal  <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (accept_issue) begin
            id_valid    <= 1'b1;
            id_instr    <= if_instr;
            id_uses_imm <= dec_uses_imm;
            id_illegal  <= dec_illegal;
            id_imm      <= dec_uses_imm ? extImm : '0;
        end else if (ex_ready) begin
            id_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imm_decode_ctrl
//
// Self-checking bench for imm_decode_ctrl. Directed scenarios plus a random
// stream compared against a transaction-level reference model. Follows the
// IMM_PREFIX_EN macro of the build to select expected prefix behaviour.
// ---------------------------------------------------------------------------
module tb_imm_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        ex_ready;
    logic        flush;
    logic [16:0] imm17;
    logic        SIG_ExtOp;
    logic [31:0] extImm;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_imm;
    logic        id_uses_imm;
    logic        id_illegal;
    logic        pfx_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    // Immediate extender in the environment.
    assign extImm = SIG_ExtOp ? {{15{imm17[16]}}, imm17} : {15'h0, imm17};

    imm_decode_ctrl #(.PFX_OPCODE(6'h3F), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush), .imm17(imm17),
        .SIG_ExtOp(SIG_ExtOp), .extImm(extImm), .id_valid(id_valid),
        .id_instr(id_instr), .id_imm(id_imm), .id_uses_imm(id_uses_imm),
        .id_illegal(id_illegal), .pfx_err(pfx_err)
    );

    // ---------------- reference model ----------------
    // kind: 0 R-type, 1 signed imm, 2 unsigned imm, 3 prefix, 4 illegal
    function automatic int kind_of(input logic [5:0] op);
        if (op == 6'h00) return 0;
        if (op inside {6'h01, 6'h04, 6'h05, 6'h06}) return 1;
        if (op inside {6'h02, 6'h03}) return 2;
`ifdef IMM_PREFIX_EN
        if (op == 6'h3F) return 3;
`endif
        return 4;
    endfunction

    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_imm = 32'h0;
    logic        m_uses = 1'b0;
    logic        m_ill = 1'b0;
    logic        m_err = 1'b0;
    logic        m_pend = 1'b0;
    logic [14:0] m_pval = 15'h0;

    function automatic logic [31:0] ext_value(input logic [31:0] ins, input int k);
        logic [31:0] v;
        v = {15'h0, ins[16:0]};
        if (k == 1 && ins[16]) v = v - 32'h0002_0000;
        return v;
    endfunction

    task automatic model_step();
        logic rdy, acc;
        int   k;
        if (reset) begin
            m_valid = 0; m_instr = 0; m_imm = 0; m_uses = 0; m_ill = 0;
            m_err = 0; m_pend = 0; m_pval = 0;
        end else if (flush) begin
            m_valid = 0; m_instr = 0; m_err = 0; m_pend = 0; m_pval = 0;
        end else begin
            rdy   = !m_valid || ex_ready;
            acc   = if_valid && rdy;
            k     = kind_of(if_instr[31:26]);
            m_err = 0;
            if (acc && k == 3) begin
                if (m_pend) m_err = 1;
                m_pend = 1;
                m_pval = if_instr[14:0];
                if (ex_ready) m_valid = 0;
            end else if (acc) begin
                m_valid = 1;
                m_instr = if_instr;
                m_uses  = (k == 1 || k == 2);
                m_ill   = (k == 4);
                if (m_uses) begin
                    m_imm = m_pend ? {m_pval, if_instr[16:0]} : ext_value(if_instr, k);
                end else begin
                    m_imm = 0;
                    if (m_pend) m_err = 1;
                end
                m_pend = 0;
            end else if (ex_ready) begin
                m_valid = 0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rs, input logic v, input logic [31:0] ins,
                         input logic er, input logic fl);
        reset = rs; if_valid = v; if_instr = ins; ex_ready = er; flush = fl;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [16:0] imm);
        return {op, 9'h0, imm};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1, 1, mk(6'h01, 17'h5), 1, 0);
        tick();
        tick();
        drive(0, 0, 32'h0, 0, 0);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", id_instr); end
        checks++; if (id_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h exp 0", id_imm); end
        checks++; if (pfx_err !== 1'b0) begin errors++; $display("FAIL reset_pfx_err got %b exp 0", pfx_err); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b exp 1", if_ready); end
    endtask

    task automatic test_signed_imm();
        drive(0, 1, mk(6'h01, 17'h1FFFF), 1, 0);
        checks++; if (SIG_ExtOp !== 1'b1) begin errors++; $display("FAIL addi_extop got %b exp 1", SIG_ExtOp); end
        checks++; if (imm17 !== 17'h1FFFF) begin errors++; $display("FAIL addi_imm17 got %h exp 1ffff", imm17); end
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", id_valid); end
        checks++; if (id_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", id_imm); end
        checks++; if (id_uses_imm !== 1'b1) begin errors++; $display("FAIL addi_uses got %b exp 1", id_uses_imm); end
    endtask

    task automatic test_stall();
        drive(0, 1, mk(6'h03, 17'h1FFFF), 1, 0);
        checks++; if (SIG_ExtOp !== 1'b0) begin errors++; $display("FAIL ori_extop got %b exp 0", SIG_ExtOp); end
        tick();
        checks++; if (id_imm !== 32'h0001_FFFF) begin errors++; $display("FAIL ori_imm got %h exp 0001ffff", id_imm); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, mk(6'h01, 17'h00123), 0, 0);
            checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", if_ready); end
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_instr !== mk(6'h03, 17'h1FFFF) || id_imm !== 32'h0001_FFFF) begin
                errors++; $display("FAIL stall_hold got %b/%h/%h exp 1/%h/0001ffff",
                                   id_valid, id_instr, id_imm, mk(6'h03, 17'h1FFFF));
            end
        end
        drive(0, 0, 32'h0, 1, 0);
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", id_valid); end
    endtask

    task automatic test_illegal();
        drive(0, 1, mk(6'h2A, 17'h00042), 1, 0);
        tick();
        checks++; if (id_illegal !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL illegal got ill=%b v=%b exp 1/1", id_illegal, id_valid); end
        checks++; if (id_uses_imm !== 1'b0) begin errors++; $display("FAIL illegal_uses got %b exp 0", id_uses_imm); end
        drive(0, 1, {6'h3F, 11'h0, 15'h1234}, 1, 0);
        tick();
`ifdef IMM_PREFIX_EN
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL pfx_no_issue got %b exp 0", id_valid); end
        drive(0, 1, mk(6'h01, 17'h05678), 1, 0);
        tick();
        checks++; if (id_imm !== 32'h2468_5678 || id_valid !== 1'b1) begin errors++; $display("FAIL pfx_pair got %h v=%b exp 24685678 v=1", id_imm, id_valid); end
        drive(0, 0, 32'h0, 1, 0);
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL pfx_single got %b exp 0", id_valid); end
`else
        checks++; if (id_illegal !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL pfx_illegal got ill=%b v=%b exp 1/1", id_illegal, id_valid); end
        checks++; if (pfx_err !== 1'b0) begin errors++; $display("FAIL pfx_err_tied got %b exp 0", pfx_err); end
        drive(0, 0, 32'h0, 1, 0);
        tick();
`endif
    endtask

`ifdef IMM_PREFIX_EN
    task automatic test_prefix_drop();
        drive(0, 1, {6'h3F, 11'h0, 15'h7FFF}, 1, 0);
        tick();
        drive(0, 1, mk(6'h00, 17'h1ABCD), 1, 0);
        tick();
        checks++; if (pfx_err !== 1'b1) begin errors++; $display("FAIL pfx_err_pulse got %b exp 1", pfx_err); end
        checks++; if (id_imm !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL pfx_rtype got %h v=%b exp 0 v=1", id_imm, id_valid); end
        drive(0, 0, 32'h0, 1, 0);
        tick();
        checks++; if (pfx_err !== 1'b0) begin errors++; $display("FAIL pfx_err_one_cycle got %b exp 0", pfx_err); end
        drive(0, 1, {6'h3F, 11'h0, 15'h1111}, 1, 0);
        tick();
        drive(0, 1, mk(6'h01, 17'h1), 1, 1);
        tick();
        checks++; if (pfx_err !== 1'b0) begin errors++; $display("FAIL flush_no_err got %b exp 0", pfx_err); end
        drive(0, 1, mk(6'h01, 17'h1), 1, 0);
        tick();
        checks++; if (id_imm !== 32'h1) begin errors++; $display("FAIL flush_kills_pfx got %h exp 1", id_imm); end
    endtask
`endif

    task automatic test_flush_ex_ready();
        drive(0, 1, mk(6'h04, 17'h00010), 1, 0);
        tick();
        drive(0, 1, mk(6'h05, 17'h00020), 1, 1);
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", if_ready); end
        tick();
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL flush_out got v=%b %h exp 0/0", id_valid, id_instr); end
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] ins;
        logic        v, er, fl, rs, exp_rdy;
        int          sel;
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = 6'h00;  1: op = 6'h01;  2: op = 6'h02;  3: op = 6'h03;
                4: op = 6'h04;  5: op = 6'h05;  6: op = 6'h06;
                7, 8: op = 6'h3F;
                default: op = 6'($urandom);
            endcase
            ins = {op, 26'($urandom)};
            v   = ($urandom_range(0, 3) != 0);
            er  = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 15) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            drive(rs, v, ins, er, fl);
            exp_rdy = !fl && (!m_valid || er);
            checks++; if (if_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, if_ready, exp_rdy); end
            checks++; if (SIG_ExtOp !== (kind_of(op) == 1)) begin errors++; $display("FAIL rnd_extop cyc %0d got %b op %h", i, SIG_ExtOp, op); end
            tick();
            checks++;
            if (id_valid !== m_valid || id_instr !== m_instr || id_imm !== m_imm ||
                id_uses_imm !== m_uses || id_illegal !== m_ill || pfx_err !== m_err) begin
                errors++;
                $display("FAIL rnd_out cyc %0d got v%b i%h m%h u%b l%b e%b exp v%b i%h m%h u%b l%b e%b",
                         i, id_valid, id_instr, id_imm, id_uses_imm, id_illegal, pfx_err,
                         m_valid, m_instr, m_imm, m_uses, m_ill, m_err);
            end
        end
    endtask

    initial begin
        drive(1, 0, 32'h0, 0, 0);
        test_reset();
        test_signed_imm();
        test_stall();
        test_illegal();
`ifdef IMM_PREFIX_EN
        test_prefix_drop();
`endif
        test_flush_ex_ready();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
